sync_fifo_flags: RTL and testbench

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

---
 rtl/sync_fifo_flags_if.sv | 32 +++
 rtl/sync_fifo_flags.sv | 126 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// The master drives the requests and push data; the slave (the FIFO) drives data and status.
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  write_req;
    logic                  read_req;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_req, read_req, data_in, clr_err,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  write_req, read_req, data_in, clr_err,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy/threshold flags, sticky error flags and
// either a registered-read or a first-word-fall-through read port.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input logic               clk,
    input logic               rst,
    sync_fifo_flags_if.slave  bus
);
    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LVL   = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_LVL   = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  rd_ok;
    logic                  wr_ok;

    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    assign rd_ok = bus.read_req && (level_q != '0);
    assign wr_ok = bus.write_req && ((level_q != FULL_LVL) || rd_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        if (wr_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
        end

        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Clear first so a same-cycle error wins over clr_err.
        if (bus.clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (bus.write_req && !wr_ok) begin
            ovf_d = 1'b1;
        end
        if (bus.read_req && !rd_ok) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[wptr_q] <= bus.data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible as soon as the level register shows it stored.
            assign bus.data_out   = (level_q != '0) ? mem_q[rptr_q] : '0;
            assign bus.data_valid = (level_q != '0);
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] dout_q, dout_d;
            logic                  dv_q, dv_d;

            always_comb begin
                dout_d = dout_q;
                dv_d   = rd_ok;
                if (rd_ok) begin
                    dout_d = mem_q[rptr_q];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    dout_q <= dout_d;
                    dv_q   <= dv_d;
                end
            end

            assign bus.data_out   = dout_q;
            assign bus.data_valid = dv_q;
        end
    endgenerate

    assign bus.level        = level_q;
    assign bus.full         = (level_q == FULL_LVL);
    assign bus.empty        = (level_q == '0);
    assign bus.almost_full  = (level_q >= AF_LVL);
    assign bus.almost_empty = (level_q <= AE_LVL);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a registered-read instance driven from a
// vector table, plus hand sequences for reset and a first-word-fall-through instance.
module tb_sync_fifo_flags;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ifa ();
    sync_fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ifb ();

    sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // flags = {full, empty, almost_full, almost_empty, overflow, underflow, data_valid}
    typedef struct {
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] din;
        logic [4:0] lvl;
        logic [6:0] flags;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] fl(input int lvl, input logic ovf, input logic udf,
                                      input logic dv);
        return {lvl == 16, lvl == 0, lvl >= 14, lvl <= 2, ovf, udf, dv};
    endfunction

    function automatic void add(input logic wr, input logic rd, input logic clr,
                                input logic [7:0] din, input int lvl, input logic ovf,
                                input logic udf, input logic dv, input logic [7:0] dout);
        vec_t v;
        v.wr    = wr;
        v.rd    = rd;
        v.clr   = clr;
        v.din   = din;
        v.lvl   = 5'(lvl);
        v.flags = fl(lvl, ovf, udf, dv);
        v.dout  = dout;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] flags_a();
        return {ifa.full, ifa.empty, ifa.almost_full, ifa.almost_empty,
                ifa.overflow, ifa.underflow, ifa.data_valid};
    endfunction

    function automatic logic [6:0] flags_b();
        return {ifb.full, ifb.empty, ifb.almost_full, ifb.almost_empty,
                ifb.overflow, ifb.underflow, ifb.data_valid};
    endfunction

    task automatic set_a(input logic wr, input logic rd, input logic clr, input logic [7:0] din);
        ifa.write_req = wr;
        ifa.read_req  = rd;
        ifa.clr_err   = clr;
        ifa.data_in   = din;
    endtask

    task automatic set_b(input logic wr, input logic rd, input logic clr, input logic [7:0] din);
        ifb.write_req = wr;
        ifb.read_req  = rd;
        ifb.clr_err   = clr;
        ifb.data_in   = din;
    endtask

    initial begin
        set_a(0, 0, 0, 8'h00);
        set_b(0, 0, 0, 8'h00);

        // Fill 0x01..0x10, then drain in order.
        for (int k = 1; k <= 16; k++) add(1, 0, 0, 8'(k), k, 0, 0, 0, 8'h00);
        for (int k = 1; k <= 16; k++) add(0, 1, 0, 8'h00, 16 - k, 0, 0, 1, 8'(k));
        add(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h10);
        // Underflow, write+read on empty, clear, read back.
        add(0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h10);
        add(1, 1, 0, 8'h55, 1, 0, 1, 0, 8'h10);
        add(0, 0, 1, 8'h00, 1, 0, 0, 0, 8'h10);
        add(0, 1, 0, 8'h00, 0, 0, 0, 1, 8'h55);
        // Refill 0x20..0x2F, overflow, clear racing a new overflow, clear.
        for (int k = 1; k <= 16; k++) add(1, 0, 0, 8'(8'h1F + k), k, 0, 0, 0, 8'h55);
        add(1, 0, 0, 8'hEE, 16, 1, 0, 0, 8'h55);
        add(1, 0, 1, 8'hEF, 16, 1, 0, 0, 8'h55);
        add(0, 0, 1, 8'h00, 16, 0, 0, 0, 8'h55);
        // Full with simultaneous write+read: oldest pops, 0x30 goes to the back.
        add(1, 1, 0, 8'h30, 16, 0, 0, 1, 8'h20);
        for (int k = 1; k <= 16; k++)
            add(0, 1, 0, 8'h00, 16 - k, 0, 0, 1, (k < 16) ? 8'(8'h20 + k) : 8'h30);
        // 40 interleaved write/read pairs, wrapping the pointers several times.
        for (int i = 0; i < 40; i++) begin
            add(1, 0, 0, 8'(8'h40 + i), 1, 0, 0, 0, (i == 0) ? 8'h30 : 8'(8'h40 + i - 1));
            add(0, 1, 0, 8'h00, 0, 0, 0, 1, 8'(8'h40 + i));
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_level_a", 32'(ifa.level), 32'd0);
        check("rst_flags_a", 32'(flags_a()), 32'(7'b0101000));
        check("rst_dout_a", 32'(ifa.data_out), 32'h00);
        check("rst_flags_b", 32'(flags_b()), 32'(7'b0101000));

        for (int i = 0; i < vecs.size(); i++) begin
            set_a(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            tick();
            check($sformatf("v%0d_level", i), 32'(ifa.level), 32'(vecs[i].lvl));
            check($sformatf("v%0d_flags", i), 32'(flags_a()), 32'(vecs[i].flags));
            check($sformatf("v%0d_dout", i), 32'(ifa.data_out), 32'(vecs[i].dout));
        end

        // Mid-stream reset with sticky error set and requests still asserted.
        set_a(0, 1, 0, 8'h00);
        tick();
        check("pre_rst_udf", 32'(ifa.underflow), 32'd1);
        for (int k = 0; k < 3; k++) begin
            set_a(1, 0, 0, 8'(8'h77 + k));
            tick();
        end
        check("pre_rst_level", 32'(ifa.level), 32'd3);
        set_a(1, 1, 0, 8'h99);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_a(0, 0, 0, 8'h00);
        check("mid_rst_level", 32'(ifa.level), 32'd0);
        check("mid_rst_flags", 32'(flags_a()), 32'(7'b0101000));
        check("mid_rst_dout", 32'(ifa.data_out), 32'h00);
        set_a(0, 1, 0, 8'h00);
        tick();
        set_a(0, 0, 0, 8'h00);
        check("post_rst_read_flags", 32'(flags_a()), 32'(7'b0101010));
        check("post_rst_read_dout", 32'(ifa.data_out), 32'h00);

        // First-word-fall-through instance.
        set_b(1, 0, 0, 8'hA5);
        tick();
        set_b(0, 0, 0, 8'h00);
        check("fwft_a5_dout", 32'(ifb.data_out), 32'hA5);
        check("fwft_a5_flags", 32'(flags_b()), 32'(7'b0001001));
        set_b(0, 1, 0, 8'h00);
        tick();
        set_b(0, 0, 0, 8'h00);
        check("fwft_pop_flags", 32'(flags_b()), 32'(7'b0101000));
        set_b(1, 0, 0, 8'hB1);
        tick();
        check("fwft_b1_dout", 32'(ifb.data_out), 32'hB1);
        set_b(1, 0, 0, 8'hB2);
        tick();
        check("fwft_b2_head", 32'(ifb.data_out), 32'hB1);
        check("fwft_b2_level", 32'(ifb.level), 32'd2);
        set_b(0, 1, 0, 8'h00);
        tick();
        check("fwft_adv_dout", 32'(ifb.data_out), 32'hB2);
        check("fwft_adv_dv", 32'(ifb.data_valid), 32'd1);
        set_b(1, 1, 0, 8'hC3);
        tick();
        check("fwft_wr_rd_dout", 32'(ifb.data_out), 32'hC3);
        check("fwft_wr_rd_level", 32'(ifb.level), 32'd1);
        set_b(0, 1, 0, 8'h00);
        tick();
        set_b(0, 0, 0, 8'h00);
        check("fwft_last_dv", 32'(ifb.data_valid), 32'd0);
        check("fwft_last_empty", 32'(ifb.empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
